// File: rtl/regfile_write_arbiter_if.sv
// Bundle between the writeback/multi-cycle requesters and the register-file write port.
// The master modport drives requests; the slave modport is the arbiter side.
interface regfile_write_arbiter_if;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mc_valid;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic        stall_wb;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;

  modport master (
    output wb_valid, wb_rd, wb_data, mc_valid, mc_rd, mc_data,
    input  mc_ready, stall_wb, rf_we, rf_a3, rf_wd
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, mc_valid, mc_rd, mc_data,
    output mc_ready, stall_wb, rf_we, rf_a3, rf_wd
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between pipeline writeback (priority) and a
// multi-cycle unit, stalling writeback for one cycle once the multi-cycle unit has starved.
module regfile_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  regfile_write_arbiter_if.slave  bus_io
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StWait, StForce} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        stall_wb_q, stall_wb_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_a3_q, rf_a3_d;
  logic [31:0] rf_wd_q, rf_wd_d;

  logic wb_use;
  logic mc_ready;

  // A writeback to x0 never claims the port, so the multi-cycle unit may use it.
  assign wb_use   = bus_io.wb_valid && (bus_io.wb_rd != 5'd0) && !stall_wb_q;
  assign mc_ready = reset_ni && bus_io.mc_valid && !wb_use;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.mc_valid && !mc_ready) begin
          cnt_d   = 4'd1;
          state_d = (Limit == 4'd1) ? StForce : StWait;
        end else begin
          cnt_d = 4'd0;
        end
      end
      StWait: begin
        if (mc_ready || !bus_io.mc_valid) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else if (cnt_q >= Limit - 4'd1) begin
          // Saturate at the limit rather than incrementing past it.
          state_d = StForce;
          cnt_d   = Limit;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StForce: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign stall_wb_d = (state_d == StForce);

  always_comb begin
    rf_we_d = 1'b0;
    rf_a3_d = rf_a3_q;
    rf_wd_d = rf_wd_q;
    if (wb_use) begin
      rf_we_d = 1'b1;
      rf_a3_d = bus_io.wb_rd;
      rf_wd_d = bus_io.wb_data;
    end else if (mc_ready && (bus_io.mc_rd != 5'd0)) begin
      rf_we_d = 1'b1;
      rf_a3_d = bus_io.mc_rd;
      rf_wd_d = bus_io.mc_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      stall_wb_q <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_a3_q    <= 5'd0;
      rf_wd_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stall_wb_q <= stall_wb_d;
      rf_we_q    <= rf_we_d;
      rf_a3_q    <= rf_a3_d;
      rf_wd_q    <= rf_wd_d;
    end
  end

  assign bus_io.mc_ready = mc_ready;
  assign bus_io.stall_wb = stall_wb_q;
  assign bus_io.rf_we    = rf_we_q;
  assign bus_io.rf_a3    = rf_a3_q;
  assign bus_io.rf_wd    = rf_wd_q;

endmodule
